keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000, meaning clk cycles each keypad column is driven.
REQ-002 SHALL have parameter DEB_FRAMES, default 4, meaning consecutive identical scan frames needed to accept a press or a release.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port key_col  output  3  one-hot, active-high column drive to the 4x3 keypad matrix.
REQ-006 SHALL have port key_row  input  4  active-high row sense from the keypad; row0 is the top row.
REQ-007 SHALL have port key_data  output  4  code of the last accepted key, consumed by the game-state block.
REQ-008 SHALL have port key_valid  output  1  single-cycle strobe marking a new key_data value.
REQ-009 SHALL have port key_held  output  1  high while an accepted key is still down.

Function
REQ-010 SHALL step key_col 001 -> 010 -> 100 -> 001, each step lasting exactly SCAN_DIV cycles.
REQ-011 SHALL sample key_row only in the last cycle of each column period.
REQ-012 SHALL define a frame as three column periods, col0 to col2, and evaluate the frame in the cycle after the col2 sample.
REQ-013 SHALL classify each frame as EMPTY (no bit set), SINGLE (exactly one bit across 12 samples) or MULTI (two or more bits).
REQ-014 SHALL encode SINGLE keys as follows: rows 0-2 give 3*row+col+1, so 1..9 for the tic-tac-toe cells; row3 col0 '*' gives 10, row3 col1 '0' gives 0, row3 col2 '#' gives 11.
REQ-015 SHALL implement FSM states IDLE, DEBOUNCE, PRESSED and RELEASE.
REQ-016 IDLE: a SINGLE frame SHALL latch the candidate code, set count=1 and move to DEBOUNCE; EMPTY or MULTI SHALL stay in IDLE.
REQ-017 DEBOUNCE: a SINGLE frame with the same code SHALL increment count.
REQ-018 DEBOUNCE: a SINGLE frame with a different code SHALL restart with the new candidate and count=1.
REQ-019 DEBOUNCE: an EMPTY or MULTI frame SHALL return the FSM to IDLE.
REQ-020 When count reaches DEB_FRAMES, the block SHALL load key_data with the candidate, pulse key_valid for exactly one cycle (the frame-evaluation cycle plus one register stage) and move to PRESSED.
REQ-021 PRESSED: SINGLE or MULTI frames SHALL cause no event; an EMPTY frame SHALL set count=1 and move to RELEASE.
REQ-022 RELEASE: each EMPTY frame SHALL increment count, and at DEB_FRAMES the FSM SHALL move to IDLE.
REQ-023 RELEASE: any non-EMPTY frame SHALL return the FSM to PRESSED.
REQ-024 SHALL provide no auto-repeat: at most one key_valid per press/release cycle.
REQ-025 key_held SHALL be high in PRESSED and RELEASE and low otherwise.
REQ-026 key_data SHALL hold its value between strobes and is not cleared on release.
REQ-027 Counters SHALL saturate and never wrap; the column divider SHALL wrap at SCAN_DIV-1.

Reset
REQ-028 On rst, key_col SHALL be 001.
REQ-029 On rst, key_data SHALL be 0 and key_valid and key_held SHALL be 0.
REQ-030 On rst, the FSM SHALL enter IDLE and all counters and the sample buffer SHALL clear.
REQ-031 A reset mid-debounce SHALL discard the candidate, and no strobe SHALL follow until a fresh full debounce completes.

Structure
REQ-032 SHALL place the FSM state encoding, key codes (KEY_STAR=10, KEY_HASH=11, KEY_ZERO=0) and frame-class encoding in shared package keypad_pkg.
REQ-033 SHALL isolate the column-period divider in sub-module scan_tick_gen (SCAN_DIV parameter, one-cycle tick output), reusable by the display multiplexers.
REQ-034 Frame classification and encoding MAY be combinational inside keypad_scan.

Verification (SCAN_DIV=4, DEB_FRAMES=4, frame=12 cycles)
REQ-035 Reset: assert rst for 2 cycles -> key_col=001, key_data=0, key_valid=0, key_held=0.
REQ-036 Hold key 5 (row1, col1) stable for 50 frames -> exactly one key_valid, key_data=5, no later than 5 frames+1 cycle after press; key_held high until 4 empty frames after release.
REQ-037 Toggle key 7 on/off every frame for 3 frames, then hold -> single strobe with key_data=7 only after 4 stable frames.
REQ-038 Press keys 1 and 9 together -> no strobe; release 9 while holding 1 -> one strobe with key_data=1.
REQ-039 Press and release '*', then '0', then '#' -> strobes with key_data 10, 0 and 11 in order; a glitch of 2 empty frames inside a hold produces no second strobe.
REQ-040 Assert rst during frame 3 of debouncing key 4 -> no strobe; key_data stays 0 until 4 new stable frames complete.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and its consumers.
// Holds FSM states, frame classes, special key codes and the matrix-to-code mapping.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        FR_EMPTY  = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_class_t;

    localparam logic [3:0] KEY_ZERO = 4'd0;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    // Top three rows map to cells 1..9; the bottom row carries '*', '0', '#'.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row != 2'd3) begin
            code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
        end else begin
            unique case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = KEY_ZERO;
                default: code = KEY_HASH;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix drive/sense plus the debounced key event bus.
// master = scanner, slave = keypad matrix and game-state consumer.
interface keypad_scan_if;
    logic [2:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_data;
    logic       key_valid;
    logic       key_held;

    modport master (output key_col, output key_data, output key_valid, output key_held,
                    input key_row);
    modport slave  (input key_col, input key_data, input key_valid, input key_held,
                    output key_row);
endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks, in the last cycle of the period.
// Latency: tick registered-count based, no backpressure; wraps at SCAN_DIV-1.
module scan_tick_gen #(
    parameter int SCAN_DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x3 keypad scanner: column drive, per-frame sampling, press/release debounce FSM.
// key_valid strobes one cycle after the frame-evaluation cycle; no backpressure, no auto-repeat.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 25000,
    parameter int DEB_FRAMES = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);
    localparam int CNTW = $clog2(DEB_FRAMES + 1);
    localparam logic [CNTW-1:0] DEB_N = CNTW'(DEB_FRAMES);

    logic             tick;
    logic [1:0]       col_idx;
    logic [2:0]       col_oh;
    logic [2:0][3:0]  samples;
    logic             frame_rdy;

    kp_state_t        state;
    logic [3:0]       cand;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  cnt_next;
    logic [3:0]       key_data_q;
    logic             key_valid_q;
    logic             key_held_q;

    frame_class_t     fclass;
    logic [3:0]       fcode;
    logic [3:0]       nset;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Rows are captured only at the end of each column period, once lines have settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx   <= 2'd0;
            col_oh    <= 3'b001;
            samples   <= '0;
            frame_rdy <= 1'b0;
        end else begin
            frame_rdy <= tick && (col_idx == 2'd2);
            if (tick) begin
                samples[col_idx] <= kp.key_row;
                col_idx          <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
                col_oh           <= {col_oh[1:0], col_oh[2]};
            end
        end
    end

    always_comb begin
        nset  = 4'd0;
        fcode = 4'd0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (samples[c][r]) begin
                    nset  = nset + 4'd1;
                    fcode = key_code(2'(r), 2'(c));
                end
            end
        end
        if (nset == 4'd0)      fclass = FR_EMPTY;
        else if (nset == 4'd1) fclass = FR_SINGLE;
        else                   fclass = FR_MULTI;
    end

    assign cnt_next = (count == DEB_N) ? count : count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cand        <= 4'd0;
            count       <= '0;
            key_data_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_rdy) begin
                unique case (state)
                    ST_IDLE: begin
                        if (fclass == FR_SINGLE) begin
                            cand  <= fcode;
                            count <= CNTW'(1);
                            if (DEB_N == CNTW'(1)) begin
                                key_data_q  <= fcode;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                state       <= ST_PRESSED;
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (fclass == FR_SINGLE && fcode == cand) begin
                            count <= cnt_next;
                            if (cnt_next == DEB_N) begin
                                key_data_q  <= cand;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                state       <= ST_PRESSED;
                            end
                        end else if (fclass == FR_SINGLE) begin
                            cand  <= fcode;
                            count <= CNTW'(1);
                        end else begin
                            count <= '0;
                            state <= ST_IDLE;
                        end
                    end
                    ST_PRESSED: begin
                        if (fclass == FR_EMPTY) begin
                            count <= CNTW'(1);
                            if (DEB_N == CNTW'(1)) begin
                                key_held_q <= 1'b0;
                                state      <= ST_IDLE;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (fclass != FR_EMPTY) begin
                            state <= ST_PRESSED;
                        end else if (cnt_next == DEB_N) begin
                            count      <= '0;
                            key_held_q <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            count <= cnt_next;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign kp.key_col   = col_oh;
    assign kp.key_data  = key_data_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Frame-level stimulus for keypad_scan, checked against a run-length reference model.
module tb_keypad_scan;
    localparam int DIV = 4;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [11:0] pressed = '0;   // bit r*3+c = key at row r, column c

    int checks = 0;
    int errors = 0;

    keypad_scan_if kif ();

    assign kif.key_row[0] = |(pressed[2:0]  & kif.key_col);
    assign kif.key_row[1] = |(pressed[5:3]  & kif.key_col);
    assign kif.key_row[2] = |(pressed[8:6]  & kif.key_col);
    assign kif.key_row[3] = |(pressed[11:9] & kif.key_col);

    keypad_scan #(.SCAN_DIV(DIV), .DEB_FRAMES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    // Strobe recorder.
    int cyc = 0;
    int got_q[$];
    int got_cyc[$];
    int wide_pulse = 0;
    logic prev_valid = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (kif.key_valid === 1'b1) begin
                got_q.push_back(int'(kif.key_data));
                got_cyc.push_back(cyc);
                if (prev_valid === 1'b1) wide_pulse++;
            end
            prev_valid = kif.key_valid;
        end
    end

    // Reference model: a key is accepted after DEB identical single-key frames,
    // released after DEB consecutive empty frames while held.
    int exp_q[$];
    int m_held = 0, m_run_len = 0, m_run_code = 0, m_empty_len = 0;
    bit pend_vld = 0;
    logic [11:0] pend = '0;

    function automatic int code_of(input int idx);
        if (idx < 9)   return idx + 1;
        if (idx == 9)  return 10;
        if (idx == 10) return 0;
        return 11;
    endfunction

    task automatic model_frame(input logic [11:0] p);
        int n, idx, code;
        n = $countones(p);
        idx = 0;
        for (int i = 0; i < 12; i++) if (p[i]) idx = i;
        code = code_of(idx);
        if (m_held == 0) begin
            if (n == 1) begin
                if (m_run_len > 0 && code == m_run_code) m_run_len++;
                else begin m_run_code = code; m_run_len = 1; end
                if (m_run_len == DEB) begin
                    exp_q.push_back(code);
                    m_held = 1;
                    m_empty_len = 0;
                end
            end else begin
                m_run_len = 0;
            end
        end else begin
            if (n == 0) begin
                m_empty_len++;
                if (m_empty_len == DEB) begin m_held = 0; m_run_len = 0; end
            end else begin
                m_empty_len = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_run_len = 0; m_empty_len = 0; pend_vld = 0;
    endtask

    // Apply pattern p for one whole frame; check key_held for the previous frame.
    task automatic do_frame(input logic [11:0] p);
        int t = 0;
        while (kif.key_col !== 3'b100 && t < 100) begin @(negedge clk); t++; end
        while (kif.key_col !== 3'b001 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            $display("FAIL frame_sync timeout key_col=%b", kif.key_col);
            errors++;
            return;
        end
        pressed = p;
        @(negedge clk);
        if (pend_vld) model_frame(pend);
        checks++;
        if (kif.key_held !== (m_held != 0)) begin
            $display("FAIL key_held got %b exp %0d (t=%0t)", kif.key_held, m_held, $time);
            errors++;
        end
        pend = p;
        pend_vld = 1;
    endtask

    task automatic frames(input logic [11:0] p, input int n);
        for (int i = 0; i < n; i++) do_frame(p);
    endtask

    task automatic start_test();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic check_strobes(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL %s strobe_count got %0d exp %0d", name, got_q.size(), exp_q.size());
            errors++;
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] != exp_q[i]) begin
                    $display("FAIL %s key_data[%0d] got %0d exp %0d", name, i, got_q[i], exp_q[i]);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks += 4;
        if (kif.key_col !== 3'b001) begin $display("FAIL reset_key_col got %b exp 001", kif.key_col); errors++; end
        if (kif.key_data !== 4'd0) begin $display("FAIL reset_key_data got %0d exp 0", kif.key_data); errors++; end
        if (kif.key_valid !== 1'b0) begin $display("FAIL reset_key_valid got %b exp 0", kif.key_valid); errors++; end
        if (kif.key_held !== 1'b0) begin $display("FAIL reset_key_held got %b exp 0", kif.key_held); errors++; end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_hold();
        int press_cyc;
        logic [11:0] k5;
        start_test();
        k5 = 12'b1 << 4;
        do_frame(k5);
        press_cyc = cyc;
        frames(k5, 49);
        frames('0, 6);
        check_strobes("hold5");
        if (got_cyc.size() > 0) begin
            checks++;
            if (got_cyc[0] - press_cyc > 5 * DIV * 3 + 1) begin
                $display("FAIL hold5_latency got %0d exp <= %0d", got_cyc[0] - press_cyc, 5 * DIV * 3 + 1);
                errors++;
            end
        end
        checks++;
        if (kif.key_data !== 4'd5) begin
            $display("FAIL hold5_data_kept got %0d exp 5", kif.key_data);
            errors++;
        end
    endtask

    task automatic test_toggle();
        logic [11:0] k7;
        start_test();
        k7 = 12'b1 << 6;
        for (int i = 0; i < 3; i++) begin do_frame(k7); do_frame('0); end
        frames(k7, 3);
        checks++;
        if (got_q.size() != 0) begin
            $display("FAIL toggle_early_strobe got %0d exp 0", got_q.size());
            errors++;
        end
        frames(k7, 3);
        frames('0, 6);
        check_strobes("toggle7");
    endtask

    task automatic test_multi();
        logic [11:0] k1, k9;
        start_test();
        k1 = 12'b1 << 0;
        k9 = 12'b1 << 8;
        frames(k1 | k9, 6);
        frames(k1, 6);
        frames('0, 6);
        check_strobes("multi1_9");
    endtask

    task automatic test_special_glitch();
        logic [11:0] ks, k0, kh;
        start_test();
        ks = 12'b1 << 9;
        k0 = 12'b1 << 10;
        kh = 12'b1 << 11;
        frames(ks, 6); frames('0, 5);
        frames(k0, 6); frames('0, 2); frames(k0, 4); frames('0, 5);
        frames(kh, 6); frames('0, 5);
        check_strobes("special");
    endtask

    task automatic test_reset_mid();
        logic [11:0] k4;
        start_test();
        k4 = 12'b1 << 3;
        frames(k4, 2);
        do_frame(k4);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        pressed = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        frames(k4, 3);
        @(negedge clk);
        checks++;
        if (kif.key_data !== 4'd0) begin
            $display("FAIL reset_mid_key_data got %0d exp 0", kif.key_data);
            errors++;
        end
        frames(k4, 3);
        frames('0, 6);
        check_strobes("reset_mid4");
    endtask

    task automatic test_random();
        logic [11:0] p;
        int kind, a, b, len, last;
        start_test();
        last = 0;
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 3);
            a = $urandom_range(0, 11);
            b = (a + $urandom_range(1, 11)) % 12;
            len = $urandom_range(1, 7);
            case (kind)
                0: p = '0;
                1: begin p = 12'b1 << a; last = a; end
                2: p = (12'b1 << a) | (12'b1 << b);
                default: p = 12'b1 << last;
            endcase
            frames(p, len);
        end
        frames('0, 6);
        check_strobes("random");
        checks++;
        if (wide_pulse != 0) begin
            $display("FAIL key_valid_width got %0d wide pulses exp 0", wide_pulse);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_toggle();
        test_multi();
        test_special_glitch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
